flow_ctrl_sender: RTL and testbench

Transmit-side counterpart of the flow-control pipeline. It accepts bytes from a local producer into a small FIFO and presents them on a Valid/Ready/Data handshake toward the pipeline's input. Data_o is held stable until the pipeline accepts it. It also keeps a transfer counter and a sticky overflow flag for debug.

---
 rtl/flow_ctrl_sender_if.sv | 31 +++
 rtl/flow_ctrl_sender.sv | 101 ++++++++++
 tb/tb_flow_ctrl_sender.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_ctrl_sender_if.sv
`default_nettype none
// ============================================================================
// flow_ctrl_sender_if : producer write port and valid/ready output port
// Rev 1.0
// ============================================================================
interface flow_ctrl_sender_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic              ready_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              overflow;
  logic [CNT_W-1:0]  tx_count;

  // master is the sender itself; slave is the producer/pipeline side
  modport master (
    input  wr_en, wr_data, ready_i,
    output full, empty, valid_o, data_o, overflow, tx_count
  );

  modport slave (
    output wr_en, wr_data, ready_i,
    input  full, empty, valid_o, data_o, overflow, tx_count
  );
endinterface
`default_nettype wire

// File: rtl/flow_ctrl_sender.sv
`default_nettype none
// ============================================================================
// flow_ctrl_sender : byte FIFO feeding a registered valid/ready output stage
// Rev 1.0
// ============================================================================
module flow_ctrl_sender #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  flow_ctrl_sender_if.master  bus
);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || ((1 << ADDR_W) != DEPTH)) begin : g_bad_depth
      $error("flow_ctrl_sender: DEPTH must be a power of 2, >= 2, and equal 2**ADDR_W");
    end
  endgenerate

  localparam logic [ADDR_W:0]  c_ptr_one = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_full;
  logic              r_empty;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_count;

  logic              w_wr;
  logic              w_xfer;
  logic              w_rd;
  logic [ADDR_W:0]   w_wr_ptr_nxt;
  logic [ADDR_W:0]   w_rd_ptr_nxt;
  logic [DATA_W-1:0] w_rd_data;

  // Full gates writes from pre-edge state, so a same-edge read never frees room
  assign w_wr   = bus.wr_en & ~r_full;
  assign w_xfer = r_valid & bus.ready_i;
  assign w_rd   = (~r_valid | w_xfer) & ~r_empty;

  assign w_wr_ptr_nxt = w_wr ? (r_wr_ptr + c_ptr_one) : r_wr_ptr;
  assign w_rd_ptr_nxt = w_rd ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;
  assign w_rd_data    = r_mem[r_rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_overflow <= 1'b0;
      r_count    <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_full   <= (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
                  (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);

      if (bus.wr_en && r_full) begin
        r_overflow <= 1'b1;
      end

      if (w_xfer) begin
        r_count <= r_count + c_cnt_one;
      end

      // Data_o keeps its last byte when the stage drains empty
      if (w_rd) begin
        r_data  <= w_rd_data;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.full     = r_full;
  assign bus.empty    = r_empty;
  assign bus.valid_o  = r_valid;
  assign bus.data_o   = r_data;
  assign bus.overflow = r_overflow;
  assign bus.tx_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_flow_ctrl_sender.sv
`default_nettype none
// ============================================================================
// tb_flow_ctrl_sender : queue-based reference model plus directed and random stimulus
// Rev 1.0
// ============================================================================
module tb_flow_ctrl_sender;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  flow_ctrl_sender_if #(.DATA_W(8), .CNT_W(8)) bus();

  flow_ctrl_sender #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(2), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, output stage as valid/data,
  // plus the list of accepted bytes in write order for delivery checking.
  logic [7:0] mq[$];
  logic [7:0] acc[$];
  logic [7:0] delivered[$];
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovf;
  logic [7:0] m_cnt;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      acc.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ovf   = 1'b0;
      m_cnt   = 8'h00;
    end else begin
      bit full_pre, xfer, rd, wr;
      check("valid_o",  {31'd0, bus.valid_o},  {31'd0, m_valid});
      check("data_o",   {24'd0, bus.data_o},   {24'd0, m_data});
      check("full",     {31'd0, bus.full},     {31'd0, (mq.size() == DEPTH)});
      check("empty",    {31'd0, bus.empty},    {31'd0, (mq.size() == 0)});
      check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
      check("tx_count", {24'd0, bus.tx_count}, {24'd0, m_cnt});

      full_pre = (mq.size() == DEPTH);
      xfer     = m_valid && bus.ready_i;
      rd       = (!m_valid || xfer) && (mq.size() > 0);
      wr       = bus.wr_en && !full_pre;

      if (bus.wr_en && full_pre) m_ovf = 1'b1;
      if (xfer) begin
        m_cnt = m_cnt + 8'd1;
        delivered.push_back(bus.data_o);
        if (acc.size() == 0) begin
          check("order_underflow", 32'd1, 32'd0);
        end else begin
          check("order", {24'd0, bus.data_o}, {24'd0, acc.pop_front()});
        end
      end
      if (rd) begin
        m_data  = mq.pop_front();
        m_valid = 1'b1;
      end else if (xfer) begin
        m_valid = 1'b0;
      end
      if (wr) begin
        mq.push_back(bus.wr_data);
        acc.push_back(bus.wr_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.wr_en   = 1'b0;
    bus.ready_i = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.ready_i = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    // 1: reset state, single byte with ready held high
    check("rst_valid",    {31'd0, bus.valid_o},  32'd0);
    check("rst_data",     {24'd0, bus.data_o},   32'd0);
    check("rst_empty",    {31'd0, bus.empty},    32'd1);
    check("rst_full",     {31'd0, bus.full},     32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("rst_count",    {24'd0, bus.tx_count}, 32'd0);
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5; bus.ready_i = 1'b1;
    cyc();
    bus.wr_en = 1'b0;
    check("t1_latency_valid", {31'd0, bus.valid_o}, 32'd0);
    cyc();
    check("t1_valid", {31'd0, bus.valid_o}, 32'd1);
    check("t1_data",  {24'd0, bus.data_o},  32'hA5);
    cyc();
    check("t1_count", {24'd0, bus.tx_count}, 32'd1);
    check("t1_idle",  {31'd0, bus.valid_o},  32'd0);
    check("t1_empty", {31'd0, bus.empty},    32'd1);

    // 2: fill with ready low, overflow, then drain
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      cyc();
    end
    check("t2_full",      {31'd0, bus.full},    32'd1);
    check("t2_hold_data", {24'd0, bus.data_o},  32'h01);
    bus.wr_data = 8'h06;
    cyc();
    bus.wr_en = 1'b0;
    check("t2_overflow",  {31'd0, bus.overflow}, 32'd1);
    check("t2_hold_data2", {24'd0, bus.data_o},  32'h01);
    bus.ready_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k < 5) check("t2_drain_data", {24'd0, bus.data_o}, 32'(1 + k));
    end
    check("t2_drain_idle", {31'd0, bus.valid_o},  32'd0);
    check("t2_count",      {24'd0, bus.tx_count}, 32'd5);

    // 3: streaming at full rate
    do_reset();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h10 + i);
      cyc();
      check("t3_not_full", {31'd0, bus.full}, 32'd0);
    end
    bus.wr_en = 1'b0;
    check("t3_count", {24'd0, bus.tx_count}, 32'd18);
    for (int i = 0; i < 4; i++) cyc();

    // 4: preloaded FIFO, ready toggling
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h20 + i);
      cyc();
    end
    bus.wr_en = 1'b0;
    cyc();
    delivered.delete();
    for (int i = 0; i < 10; i++) begin
      bus.ready_i = (i % 2 == 0);
      cyc();
    end
    check("t4_ndeliv", delivered.size(), 32'd4);
    for (int i = 0; i < delivered.size() && i < 4; i++) begin
      check("t4_seq", {24'd0, delivered[i]}, 32'(8'h20 + i));
    end

    // 5: asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h40 + i);
      cyc();
    end
    bus.wr_en = 1'b0;
    cyc();
    check("t5_pre_valid", {31'd0, bus.valid_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_async_valid", {31'd0, bus.valid_o},  32'd0);
    check("t5_async_data",  {24'd0, bus.data_o},   32'd0);
    check("t5_async_empty", {31'd0, bus.empty},    32'd1);
    check("t5_async_ovf",   {31'd0, bus.overflow}, 32'd0);
    check("t5_async_count", {24'd0, bus.tx_count}, 32'd0);
    cyc();
    rst = 1'b0;
    bus.wr_en = 1'b1; bus.wr_data = 8'h77; bus.ready_i = 1'b0;
    cyc();
    bus.wr_en = 1'b0;
    cyc();
    check("t5_after_valid", {31'd0, bus.valid_o}, 32'd1);
    check("t5_after_data",  {24'd0, bus.data_o},  32'h77);
    bus.ready_i = 1'b1;
    cyc();

    // 6: counter wrap after 256 transfers
    do_reset();
    bus.ready_i = 1'b1;
    for (int i = 1; i <= 258; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i * 7);
      cyc();
      if (i == 257) check("t6_count_255", {24'd0, bus.tx_count}, 32'd255);
    end
    check("t6_count_wrap", {24'd0, bus.tx_count}, 32'd0);
    bus.wr_en = 1'b0;
    for (int i = 0; i < 4; i++) cyc();

    // Random traffic at several write/ready densities
    for (int ph = 0; ph < 3; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 80 : (ph == 1) ? 50 : 30;
      pr = (ph == 0) ? 40 : (ph == 1) ? 50 : 90;
      for (int i = 0; i < 400; i++) begin
        bus.wr_en   = ($urandom_range(0, 99) < pw);
        bus.wr_data = 8'($urandom);
        bus.ready_i = ($urandom_range(0, 99) < pr);
        cyc();
      end
    end
    bus.wr_en = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    check("final_drained", {31'd0, bus.valid_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
